// File: rtl/mem_param_pkg.sv
// Shared types, limits and the byte-merge helper for the mem_param storage block.
package mem_param_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int unsigned MAX_RD_LAT = 4;
  localparam int unsigned MAX_DATA_W = 1024;

  // Operates at MAX_DATA_W so one function serves every DATA_W; callers size-cast in and out.
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0]   old_word,
    input logic [MAX_DATA_W-1:0]   new_word,
    input logic [MAX_DATA_W/8-1:0] be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MAX_DATA_W/8; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_param_rsp_pipe.sv
// RD_LAT-deep {valid, err, data} response delay line; reset flushes all stages.
module mem_param_rsp_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0]             v_q;
  logic [RD_LAT-1:0]             e_q;
  logic [RD_LAT-1:0][DATA_W-1:0] d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      e_q <= '0;
      d_q <= '0;
    end else begin
      v_q[0] <= in_valid;
      e_q[0] <= in_err;
      d_q[0] <= in_data;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        e_q[i] <= e_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[RD_LAT-1];
  assign out_err   = v_q[RD_LAT-1] & e_q[RD_LAT-1];
  assign out_data  = v_q[RD_LAT-1] ? d_q[RD_LAT-1] : '0;

endmodule

// File: rtl/mem_param.sv
// Parametrised single-port synchronous RAM with byte enables, in-order fixed-latency
// responses, out-of-range error flag and optional post-reset zero fill.
module mem_param
  import mem_param_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned RD_LAT         = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(DEPTH - 1);

  if ((DATA_W % 8) != 0 || DATA_W == 0 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("mem_param: DATA_W must be a non-zero multiple of 8 up to MAX_DATA_W");
  end
  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
    $error("mem_param: RD_LAT out of range 1..MAX_RD_LAT");
  end
  if (DEPTH < 1 || DEPTH > (2**ADDR_W)) begin : g_bad_depth
    $error("mem_param: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W:0]   clr_cnt;
  logic              clr_we;
  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] stg_data;

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST_X) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  assign req_ready = (state == RUN) && !rst;
  assign busy      = (state == CLEAR);
  assign accept    = req_valid && req_ready;

  // Range test is done one bit wider than the address so DEPTH == 2**ADDR_W never flags.
  assign in_range = {1'b0, req_addr} < DEPTH_X;
  assign idx      = req_addr[IDX_W-1:0];
  assign clr_idx  = clr_cnt[IDX_W-1:0];
  assign clr_we   = (state == CLEAR) && !rst;

  assign rd_word  = in_range ? mem[idx] : '0;
  assign wr_word  = DATA_W'(be_merge(MAX_DATA_W'(rd_word), MAX_DATA_W'(req_wdata),
                                     (MAX_DATA_W/8)'(req_be)));
  assign stg_data = (accept && !req_write) ? rd_word : '0;

  // Storage has no reset; only the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (accept && req_write && in_range) begin
      mem[idx] <= wr_word;
    end
  end

  mem_param_rsp_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_err    (accept && !in_range),
    .in_data   (stg_data),
    .out_valid (rsp_valid),
    .out_err   (rsp_err),
    .out_data  (rsp_rdata)
  );

endmodule

// File: tb/tb_mem_param.sv
// Scoreboard bench for mem_param: 32-bit words, 20 entries in a 5-bit space, 3-cycle latency.
module tb_mem_param;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 20;
  localparam int unsigned RD_LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [3:0]        req_be = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  mem_param #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .RD_LAT         (RD_LAT),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errs = 0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, "_data"}, 64'(rsp_rdata), 64'(mon_e.data));
          chk({mon_e.name, "_err"},  64'(rsp_err),   64'(mon_e.err));
          chk({mon_e.name, "_lat"},  64'(cyc),       64'(mon_e.cyc));
        end
      end else begin
        chk("idle_zero", {31'd0, rsp_err, rsp_rdata}, 64'd0);
      end
    end
  end

  // Called at posedge+#1; the request is accepted on the following edge.
  task automatic issue(input string name, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic eerr, input logic [31:0] edata);
    exp_t e;
    chk({name, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    e.name = name;
    e.err  = eerr;
    e.data = edata;
    e.cyc  = cyc + RD_LAT;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic wait_clear();
    int unsigned n;
    n = 0;
    chk("ready_during_clear", 64'(req_ready), 64'd0);
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("clear_cycles", 64'(n), 64'(DEPTH));
    chk("ready_after_clear", 64'(req_ready), 64'd1);
  endtask

  function automatic logic [31:0] exp_word(input int unsigned a);
    case (a)
      0:       return 32'hCAFE0000;
      1:       return 32'h12345678;
      2:       return 32'hDEADBEEF;
      3:       return 32'h000000A5;
      7:       return 32'h11BB33DD;
      19:      return 32'h19191919;
      default: return 32'h00000000;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy",      64'(busy),      64'd1);
    rst = 1'b0;
    wait_clear();

    for (int unsigned a = 0; a < DEPTH; a++)
      issue($sformatf("clr_rd%0d", a), 1'b0, ADDR_W'(a), 32'h0, 4'h0, 1'b0, 32'h0);

    issue("wr3", 1'b1, 5'd3, 32'h000000A5, 4'hF, 1'b0, 32'h0);
    issue("rd3", 1'b0, 5'd3, 32'h0,        4'h0, 1'b0, 32'h000000A5);

    issue("wr7_full", 1'b1, 5'd7, 32'h11223344, 4'hF,    1'b0, 32'h0);
    issue("wr7_be",   1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0);
    issue("rd7",      1'b0, 5'd7, 32'h0,        4'h0,    1'b0, 32'h11BB33DD);
    issue("wr7_be0",  1'b1, 5'd7, 32'hFFFFFFFF, 4'h0,    1'b0, 32'h0);
    issue("rd7_be0",  1'b0, 5'd7, 32'h0,        4'h0,    1'b0, 32'h11BB33DD);

    issue("wr0", 1'b1, 5'd0, 32'hCAFE0000, 4'hF, 1'b0, 32'h0);
    issue("wr1", 1'b1, 5'd1, 32'h12345678, 4'hF, 1'b0, 32'h0);
    issue("wr2", 1'b1, 5'd2, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    issue("b2b_rd0", 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 32'hCAFE0000);
    issue("b2b_rd1", 1'b0, 5'd1, 32'h0, 4'h0, 1'b0, 32'h12345678);
    issue("b2b_rd2", 1'b0, 5'd2, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);

    issue("oor_wr25", 1'b1, 5'd25, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
    issue("oor_rd25", 1'b0, 5'd25, 32'h0,        4'h0, 1'b1, 32'h0);
    issue("oor_wr20", 1'b1, 5'd20, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
    issue("oor_rd31", 1'b0, 5'd31, 32'h0,        4'h0, 1'b1, 32'h0);
    issue("wr19",     1'b1, 5'd19, 32'h19191919, 4'hF, 1'b0, 32'h0);
    for (int unsigned a = 0; a < DEPTH; a++)
      issue($sformatf("sweep_rd%0d", a), 1'b0, ADDR_W'(a), 32'h0, 4'h0, 1'b0, exp_word(a));

    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Read accepted but never scoreboarded: reset must swallow its response.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy",      64'(busy),      64'd1);
    chk("midrst_ready",     64'(req_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("busy_after_rst", 64'(busy), 64'd1);
    wait_clear();
    issue("post_rst_rd3", 1'b0, 5'd3, 32'h0, 4'h0, 1'b0, 32'h0);
    issue("post_rst_rd7", 1'b0, 5'd7, 32'h0, 4'h0, 1'b0, 32'h0);

    repeat (RD_LAT + 2) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
